// File: rtl/vga_update_arbiter.sv
// -----------------------------------------------------------------------------
// vga_update_arbiter
//
// Purpose:
//   Serialises tile-map writes from two requesters (0 = game logic,
//   1 = cursor) into a single tile-RAM write port. Writes are allowed only
//   while the VGA generator is in vertical blanking, so the renderer never
//   reads a tile that is being rewritten mid-frame. Contention is resolved
//   round-robin. The block also emits a one-cycle frame_tick at every
//   blanking entry and keeps an 8-bit wrapping count of those ticks.
//
// Ports:
//   clk          in   pixel clock (25 MHz)
//   reset        in   asynchronous, active-high reset
//   linha        in   current line index from the sync generator
//   coluna       in   current column index (monitored only, no effect)
//   req0/req1    in   write requests; addr/data held stable while high
//   addr0/addr1  in   tile address of each requester
//   data0/data1  in   tile code of each requester
//   gnt0/gnt1    out  one-cycle grant pulse (registered)
//   wr_en        out  tile-RAM write strobe (registered)
//   wr_addr      out  tile-RAM write address, holds last written value
//   wr_data      out  tile-RAM write data, holds last written value
//   frame_tick   out  one-cycle pulse on vertical-blanking entry
//   frame_count  out  number of blanking entries since reset, wraps 255->0
// -----------------------------------------------------------------------------
module vga_update_arbiter #(
  parameter int LINHASATIVAS = 480,
  parameter int TOTALLINHAS  = 524,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        linha,
  input  logic [9:0]        coluna,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_tick,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_BLANK  = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  // First blanking line and last line of the frame (guard line).
  localparam logic [9:0] L_FIRST_BLANK = 10'(LINHASATIVAS);
  localparam logic [9:0] L_GUARD       = 10'(TOTALLINHAS - 1);

  // Round-robin pick: a lone requester wins; on a tie the requester that was
  // not granted last wins. Returns the winning requester index.
  function automatic logic pick_winner(input logic a_req0,
                                       input logic a_req1,
                                       input logic a_last);
    logic v_win;
    if (a_req0 && a_req1) begin
      v_win = ~a_last;
    end else if (a_req1) begin
      v_win = 1'b1;
    end else begin
      v_win = 1'b0;
    end
    return v_win;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_frame_tick;
  logic [7:0]          r_frame_count;
  logic                r_last;       // index of the requester granted last

  logic                w_gnt0_nxt;
  logic                w_gnt1_nxt;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic                w_frame_tick_nxt;
  logic [7:0]          w_frame_count_nxt;
  logic                w_last_nxt;

  logic                w_blank_entry;
  logic                w_guard_line;
  logic                w_active_line;
  logic                w_any_req;
  logic                w_winner;
  logic                w_unused_coluna;

  assign w_blank_entry   = (linha == L_FIRST_BLANK);
  assign w_guard_line    = (linha == L_GUARD);
  assign w_active_line   = (linha < L_FIRST_BLANK);
  assign w_any_req       = req0 | req1;
  assign w_winner        = pick_winner(req0, req1, r_last);

  // The column index is observed but does not influence arbitration.
  assign w_unused_coluna = ^coluna;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Leaving BLANK/GRANT also happens if the line index is
  // back in the visible range, so a generator restart during blanking can
  // never let a write land on an active line.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACTIVE: begin
        if (w_blank_entry) begin
          w_state_nxt = ST_BLANK;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_BLANK: begin
        if (w_guard_line || w_active_line) begin
          w_state_nxt = ST_ACTIVE;
        end else if (w_any_req) begin
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_GRANT: begin
        if (w_guard_line || w_active_line) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      default: begin
        w_state_nxt = ST_ACTIVE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs. Grant outputs are
  // prepared on the BLANK->GRANT transition so they are visible exactly
  // during the GRANT cycle; address/data are captured at that same edge.
  always_comb begin
    w_gnt0_nxt        = 1'b0;
    w_gnt1_nxt        = 1'b0;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_last_nxt        = r_last;
    w_frame_tick_nxt  = 1'b0;
    w_frame_count_nxt = r_frame_count;

    if ((r_state == ST_BLANK) && (w_state_nxt == ST_GRANT)) begin
      w_wr_en_nxt = 1'b1;
      w_last_nxt  = w_winner;
      if (w_winner) begin
        w_gnt1_nxt    = 1'b1;
        w_wr_addr_nxt = addr1;
        w_wr_data_nxt = data1;
      end else begin
        w_gnt0_nxt    = 1'b1;
        w_wr_addr_nxt = addr0;
        w_wr_data_nxt = data0;
      end
    end else begin
      w_wr_en_nxt = 1'b0;
    end

    if ((r_state == ST_ACTIVE) && (w_state_nxt == ST_BLANK)) begin
      w_frame_tick_nxt  = 1'b1;
      w_frame_count_nxt = r_frame_count + 8'd1;
    end else begin
      w_frame_tick_nxt  = 1'b0;
    end
  end

  // Output and pointer registers. Reset leaves the pointer at "last granted
  // 1" so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= {ADDR_W{1'b0}};
      r_wr_data     <= {DATA_W{1'b0}};
      r_frame_tick  <= 1'b0;
      r_frame_count <= 8'd0;
      r_last        <= 1'b1;
    end else begin
      r_gnt0        <= w_gnt0_nxt;
      r_gnt1        <= w_gnt1_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_frame_tick  <= w_frame_tick_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_last        <= w_last_nxt;
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_update_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_update_arbiter
//
// Directed stimulus drives the line index and the two requesters. Each
// stimulus step pushes the expected write / frame tick (with the cycle in
// which it must appear) onto a queue; a monitor on the falling edge pops and
// compares whenever the DUT shows wr_en/gnt or frame_tick, and checks that
// wr_addr/wr_data hold their last value otherwise.
// -----------------------------------------------------------------------------
module tb_vga_update_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] linha;
  logic [9:0] coluna;
  logic       req0, req1;
  logic [6:0] addr0, addr1;
  logic [3:0] data0, data1;
  logic       gnt0, gnt1, wr_en;
  logic [6:0] wr_addr;
  logic [3:0] wr_data;
  logic       frame_tick;
  logic [7:0] frame_count;

  vga_update_arbiter #(
    .LINHASATIVAS(480),
    .TOTALLINHAS (524),
    .ADDR_W      (7),
    .DATA_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .linha      (linha),
    .coluna     (coluna),
    .req0       (req0),
    .req1       (req1),
    .addr0      (addr0),
    .addr1      (addr1),
    .data0      (data0),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_tick (frame_tick),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Posedge counter; outputs registered at posedge N are seen with cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int who; int addr; int data; } wr_t;
  typedef struct { int cyc; int cnt; } ft_t;
  wr_t wr_q[$];
  ft_t ft_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      coluna = coluna + 10'd1;
    end
  endtask

  task automatic push_wr(input int off, input int who, input int a, input int d);
    wr_t e;
    e.cyc = cyc + off; e.who = who; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_ft(input int off, input int cnt);
    ft_t e;
    e.cyc = cyc + off; e.cnt = cnt;
    ft_q.push_back(e);
  endtask

  // Monitor / scoreboard
  int  m_addr = 0;
  int  m_data = 0;
  wr_t mw;
  ft_t mf;
  always @(negedge clk) begin
    if (reset) begin
      m_addr = 0;
      m_data = 0;
    end else begin
      if (wr_en || gnt0 || gnt1) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got wr_en=%0b gnt0=%0b gnt1=%0b addr=%0h at cyc %0d, expected no write",
                   wr_en, gnt0, gnt1, wr_addr, cyc);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_cycle", cyc, mw.cyc);
          chk("wr_en", {31'd0, wr_en}, 32'd1);
          chk("gnt0", {31'd0, gnt0}, (mw.who == 0) ? 32'd1 : 32'd0);
          chk("gnt1", {31'd0, gnt1}, (mw.who == 1) ? 32'd1 : 32'd0);
          chk("wr_addr", {25'd0, wr_addr}, mw.addr);
          chk("wr_data", {28'd0, wr_data}, mw.data);
          m_addr = mw.addr;
          m_data = mw.data;
        end
      end else begin
        chk("wr_addr_hold", {25'd0, wr_addr}, m_addr);
        chk("wr_data_hold", {28'd0, wr_data}, m_data);
      end
      if (frame_tick) begin
        if (ft_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_tick: got tick at cyc %0d count %0d, expected none", cyc, frame_count);
        end else begin
          mf = ft_q.pop_front();
          chk("tick_cycle", cyc, mf.cyc);
          chk("frame_count", {24'd0, frame_count}, mf.cnt);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    linha = 10'd479; coluna = 10'd0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 7'd0; addr1 = 7'd0; data0 = 4'd0; data1 = 4'd0;
    tick(2);

    // Reset values
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {28'd0, wr_data}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_frame_count", {24'd0, frame_count}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Blanking entry with no requests
    linha = 10'd480; push_ft(1, 1); tick(3);
    linha = 10'd523; tick(1);
    linha = 10'd0;   tick(2);

    // Request during active lines waits for blanking
    linha = 10'd100; req0 = 1'b1; addr0 = 7'h2A; data0 = 4'h5; tick(4);
    linha = 10'd479; tick(1);
    linha = 10'd480; push_ft(1, 2); push_wr(2, 0, 'h2A, 'h5); tick(2);
    req0 = 1'b0; tick(2);

    // Request on the guard line is served after the next blanking entry
    linha = 10'd523; req1 = 1'b1; addr1 = 7'h11; data1 = 4'hA; tick(1);
    linha = 10'd0;   tick(3);
    linha = 10'd479; tick(1);
    linha = 10'd480; push_ft(1, 3); push_wr(2, 1, 'h11, 'hA); tick(2);
    req1 = 1'b0; tick(2);

    // Reset in the middle of a grant cycle (pointer is "last 1" here)
    req0 = 1'b1; addr0 = 7'h33; data0 = 4'h7; tick(1);
    chk("pre_reset_wr_en", {31'd0, wr_en}, 32'd1);
    chk("pre_reset_gnt0", {31'd0, gnt0}, 32'd1);
    reset = 1'b1; req0 = 1'b0;
    #1;
    chk("async_wr_en", {31'd0, wr_en}, 32'd0);
    chk("async_gnt0", {31'd0, gnt0}, 32'd0);
    chk("async_frame_count", {24'd0, frame_count}, 32'd0);
    chk("async_wr_addr", {25'd0, wr_addr}, 32'd0);
    linha = 10'd479; tick(2);
    reset = 1'b0; tick(3);

    // Both requesters held: alternating grants every 2 cycles, 0 first
    linha = 10'd480; req0 = 1'b1; req1 = 1'b1;
    addr0 = 7'h01; data0 = 4'h1; addr1 = 7'h02; data1 = 4'h2;
    push_ft(1, 1);
    push_wr(2, 0, 'h01, 'h1);
    push_wr(4, 1, 'h02, 'h2);
    push_wr(6, 0, 'h03, 'h3);
    push_wr(8, 1, 'h02, 'h2);
    tick(2);
    addr0 = 7'h03; data0 = 4'h3; tick(6);
    req0 = 1'b0; req1 = 1'b0; tick(3);
    linha = 10'd523; tick(1);
    linha = 10'd0;   tick(1);

    // Request withdrawn during active lines, then generator restart to line 0
    linha = 10'd300; req1 = 1'b1; addr1 = 7'h44; data1 = 4'h4; tick(2);
    req1 = 1'b0; tick(1);
    linha = 10'd0; tick(2);
    linha = 10'd1; tick(1);
    linha = 10'd479; tick(1);
    linha = 10'd480; push_ft(1, 2); tick(4);
    linha = 10'd523; tick(1);
    linha = 10'd0;   tick(1);

    // 256 frames from reset: count wraps to 0 on the 256th tick
    reset = 1'b1; tick(1);
    reset = 1'b0;
    chk("frames_start_count", {24'd0, frame_count}, 32'd0);
    tick(1);
    for (int k = 1; k <= 256; k++) begin
      linha = 10'd479; tick(1);
      linha = 10'd480; push_ft(1, k % 256); tick(1);
      linha = 10'd523; tick(1);
      linha = 10'd0;   tick(1);
    end
    chk("wrap_count", {24'd0, frame_count}, 32'd0);
    tick(4);

    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending expected 0", wr_q.size());
    end
    checks++;
    if (ft_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frame_ticks: got %0d pending expected 0", ft_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_update_arbiter.md
VGA_UPDATE_ARBITER -- requirements
Module: vga_update_arbiter

Interface
- REQ-001: Parameter LINHASATIVAS, default 480, number of active lines.
- REQ-002: Parameter TOTALLINHAS, default 524, total lines per frame.
- REQ-003: Parameter ADDR_W, default 7, tile-map address width (10x10 board = 100 tiles).
- REQ-004: Parameter DATA_W, default 4, tile code width.
- REQ-005: clk  input  1  pixel clock, 25 MHz.
- REQ-006: reset  input  1  asynchronous, active-high reset.
- REQ-007: linha  input  10  current line index from the VGA sync generator.
- REQ-008: coluna  input  10  current column index from the VGA sync generator; monitored only.
- REQ-009: req0, req1  input  1 each  write requests from requester 0 (game logic) and requester 1 (cursor).
- REQ-010: addr0, addr1  input  ADDR_W each  tile address, held stable while the matching req is high.
- REQ-011: data0, data1  input  DATA_W each  tile code, held stable while the matching req is high.
- REQ-012: gnt0, gnt1  output  1 each  one-cycle grant pulses.
- REQ-013: wr_en  output  1  tile-RAM write strobe.
- REQ-014: wr_addr  output  ADDR_W  tile-RAM write address.
- REQ-015: wr_data  output  DATA_W  tile-RAM write data.
- REQ-016: frame_tick  output  1  one-cycle pulse at vertical-blanking entry.
- REQ-017: frame_count  output  8  count of blanking entries since reset.
- REQ-018: All outputs SHALL be registered on posedge clk.

Function
- REQ-019: FSM states SHALL be ACTIVE, BLANK, GRANT.
- REQ-020: ACTIVE->BLANK SHALL occur at the edge where linha == LINHASATIVAS; frame_tick SHALL be 1 for exactly that following cycle.
- REQ-021: BLANK->ACTIVE SHALL occur when linha == TOTALLINHAS-1 (guard line); no grant SHALL be issued on the guard line or during active lines.
- REQ-022: BLANK->GRANT SHALL occur when req0 or req1 is high and linha is not the guard line.
- REQ-023: GRANT SHALL last exactly one cycle, then return to BLANK, or to ACTIVE if linha == TOTALLINHAS-1.
- REQ-024: In GRANT, wr_en SHALL be 1, exactly one gnt_i SHALL be 1, and wr_addr/wr_data SHALL equal the addr_i/data_i sampled at the BLANK->GRANT edge.
- REQ-025: A requester SHALL deassert or change its request on the edge that ends its gnt cycle. Writes SHALL therefore occur at most once per 2 cycles.
- REQ-026: Arbitration SHALL be round-robin. With a single requester, that requester wins. With both requesting, the requester not granted last wins.
- REQ-027: The last-granted pointer SHALL update only on grant. After reset, requester 0 SHALL win the first tie.
- REQ-028: A req deasserted before it is sampled in BLANK SHALL produce no grant or write.
- REQ-029: A req pending in ACTIVE SHALL stay pending; it SHALL be served in the next BLANK, in arbitration order.
- REQ-030: Outside GRANT, wr_en, gnt0 and gnt1 SHALL be 0. wr_addr/wr_data SHALL hold their last values.
- REQ-031: frame_count SHALL increment with each frame_tick and wrap 255->0.
- REQ-032: If linha jumps directly from a value below LINHASATIVAS to 0 (generator reset), the FSM SHALL stay in ACTIVE and issue no frame_tick.

Reset
- REQ-033: Reset asserted SHALL immediately force: state ACTIVE, gnt0=gnt1=wr_en=0, wr_addr=0, wr_data=0, frame_tick=0, frame_count=0, pointer = "last granted 1".
- REQ-034: Reset asserted during GRANT SHALL abort the write asynchronously, with no residual wr_en pulse after release.
- REQ-035: After reset release, the first blanking entry SHALL produce frame_tick and frame_count=1.

Verification
- REQ-036: Drive linha 479->480 with no requests -> frame_tick=1 for one cycle, frame_count 0->1, no wr_en.
- REQ-037: req0=1, addr0=0x2A, data0=0x5 during active lines -> no grant until linha=480; then gnt0=1, wr_en=1, wr_addr=0x2A, wr_data=0x5 for one cycle.
- REQ-038: req0 and req1 held high throughout blanking -> grants alternate 0,1,0,1, one every 2 cycles, starting with 0 after reset.
- REQ-039: req1 asserted on the guard line (linha=523) -> no grant; gnt1 is issued after the next linha=480.
- REQ-040: Assert reset during a GRANT cycle -> wr_en and gnt drop in the same cycle; frame_count=0; the next tie goes to requester 0.
- REQ-041: Run 256 frames -> frame_count wraps to 0 on the 256th frame_tick.
